scoreboard: RTL and testbench

SCOREBOARD -- requirements
Module: scoreboard

---
 rtl/scoreboard_if.sv | 33 +++
 rtl/scoreboard.sv | 114 +++++++++++
 tb/tb_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_if.sv
// Scoreboard request/observe bus: the bench drives requests and observed data.
// The scoreboard returns expected data, occupancy, and compare status.
interface scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  logic                     i_req0;
  logic                     i_req1;
  logic [WIDTH-1:0]         i_data_in;
  logic [WIDTH-1:0]         i_data_obs;
  logic [WIDTH-1:0]         o_exp_data;
  logic                     o_exp_valid;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_full;
  logic                     o_empty;
  logic                     o_mismatch;
  logic [15:0]              o_match_cnt;
  logic [15:0]              o_err_cnt;
  logic                     o_overflow;
  logic                     o_underflow;

  modport master (
    output i_req0, i_req1, i_data_in, i_data_obs,
    input  o_exp_data, o_exp_valid, o_count, o_full, o_empty, o_mismatch,
           o_match_cnt, o_err_cnt, o_overflow, o_underflow
  );

  modport slave (
    input  i_req0, i_req1, i_data_in, i_data_obs,
    output o_exp_data, o_exp_valid, o_count, o_full, o_empty, o_mismatch,
           o_match_cnt, o_err_cnt, o_overflow, o_underflow
  );
endinterface

// File: rtl/scoreboard.sv
// Reference-model scoreboard: it models a FIFO or stack, predicts popped data one cycle after the pop,
// and compares that prediction with the observed data. Rejected requests raise sticky flags.
module scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LIFO  = 0
) (
  input  logic         clk,
  input  logic         rst,
  scoreboard_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [WIDTH-1:0] r_exp_data;
  logic             r_exp_valid;
  logic             r_mismatch;
  logic [15:0]      r_match_cnt;
  logic [15:0]      r_err_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_top;
  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_pop       = bus.i_req1 && !r_empty;
    w_push      = bus.i_req0 && (!r_full || w_pop);
    w_top       = r_count[AW-1:0] - AW'(1);
    w_rd_addr   = r_rd_ptr;
    w_wr_addr   = r_wr_ptr;
    // In stack mode a simultaneous push overwrites the slot being popped.
    if (LIFO != 0) begin
      w_rd_addr = w_top;
      w_wr_addr = w_pop ? w_top : r_count[AW-1:0];
    end
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[w_wr_addr] <= bus.i_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_exp_data  <= '0;
      r_exp_valid <= 1'b0;
      r_mismatch  <= 1'b0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_empty     <= (w_count_nxt == '0);
      if (LIFO == 0) begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_exp_valid <= w_pop;
      if (w_pop)
        r_exp_data <= r_mem[w_rd_addr];
      if (bus.i_req0 && !w_push)
        r_overflow <= 1'b1;
      if (bus.i_req1 && !w_pop)
        r_underflow <= 1'b1;
      r_mismatch <= 1'b0;
      if (r_exp_valid) begin
        if (bus.i_data_obs == r_exp_data) begin
          if (r_match_cnt != 16'hFFFF)
            r_match_cnt <= r_match_cnt + 16'd1;
        end else begin
          r_mismatch <= 1'b1;
          if (r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.o_exp_data  = r_exp_data;
  assign bus.o_exp_valid = r_exp_valid;
  assign bus.o_count     = r_count;
  assign bus.o_full      = r_full;
  assign bus.o_empty     = r_empty;
  assign bus.o_mismatch  = r_mismatch;
  assign bus.o_match_cnt = r_match_cnt;
  assign bus.o_err_cnt   = r_err_cnt;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_underflow = r_underflow;
endmodule

// File: tb/tb_scoreboard.sv
// Directed bench: a FIFO-mode and a LIFO-mode scoreboard share clock and reset.
module tb_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  scoreboard_if #(.WIDTH(32), .DEPTH(16)) f_if ();
  scoreboard_if #(.WIDTH(32), .DEPTH(16)) l_if ();

  scoreboard #(.WIDTH(32), .DEPTH(16), .LIFO(0)) u_fifo (.clk(clk), .rst(rst), .bus(f_if));
  scoreboard #(.WIDTH(32), .DEPTH(16), .LIFO(1)) u_lifo (.clk(clk), .rst(rst), .bus(l_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    f_if.i_req0 = 1'b0; f_if.i_req1 = 1'b0; f_if.i_data_in = '0; f_if.i_data_obs = '0;
    l_if.i_req0 = 1'b0; l_if.i_req1 = 1'b0; l_if.i_data_in = '0; l_if.i_data_obs = '0;
    #3;
    chk("rst_count", 32'(f_if.o_count), 0);
    chk("rst_empty", 32'(f_if.o_empty), 1);
    chk("rst_full", 32'(f_if.o_full), 0);
    chk("rst_exp_valid", 32'(f_if.o_exp_valid), 0);
    chk("rst_exp_data", f_if.o_exp_data, 0);
    chk("rst_mismatch", 32'(f_if.o_mismatch), 0);
    chk("rst_match_cnt", 32'(f_if.o_match_cnt), 0);
    chk("rst_err_cnt", 32'(f_if.o_err_cnt), 0);
    chk("rst_overflow", 32'(f_if.o_overflow), 0);
    chk("rst_underflow", 32'(f_if.o_underflow), 0);
    #4 rst = 1'b0;

    // FIFO ordering
    f_if.i_req0 = 1'b1;
    f_if.i_data_in = 32'h11; cyc;
    f_if.i_data_in = 32'h22; cyc;
    f_if.i_data_in = 32'h33; cyc;
    f_if.i_req0 = 1'b0;
    chk("fifo_count3", 32'(f_if.o_count), 3);
    f_if.i_req1 = 1'b1; cyc;
    chk("fifo_vld1", 32'(f_if.o_exp_valid), 1);
    chk("fifo_pop1", f_if.o_exp_data, 32'h11);
    f_if.i_data_obs = 32'h11; cyc;
    chk("fifo_pop2", f_if.o_exp_data, 32'h22);
    f_if.i_data_obs = 32'h22; cyc;
    chk("fifo_pop3", f_if.o_exp_data, 32'h33);
    f_if.i_data_obs = 32'h33;
    f_if.i_req1 = 1'b0; cyc;
    chk("fifo_vld_off", 32'(f_if.o_exp_valid), 0);
    chk("fifo_match3", 32'(f_if.o_match_cnt), 3);
    chk("fifo_err0", 32'(f_if.o_err_cnt), 0);
    chk("fifo_empty", 32'(f_if.o_empty), 1);

    // LIFO ordering, then a simultaneous push/pop replacing the top
    l_if.i_req0 = 1'b1;
    l_if.i_data_in = 32'hA; cyc;
    l_if.i_data_in = 32'hB; cyc;
    l_if.i_data_in = 32'hC; cyc;
    l_if.i_req0 = 1'b0;
    l_if.i_req1 = 1'b1; cyc;
    chk("lifo_pop_c", l_if.o_exp_data, 32'hC);
    l_if.i_data_obs = 32'hC; cyc;
    chk("lifo_pop_b", l_if.o_exp_data, 32'hB);
    l_if.i_data_obs = 32'hB; cyc;
    chk("lifo_pop_a", l_if.o_exp_data, 32'hA);
    l_if.i_data_obs = 32'hA;
    l_if.i_req1 = 1'b0; cyc;
    chk("lifo_empty", 32'(l_if.o_empty), 1);
    chk("lifo_match3", 32'(l_if.o_match_cnt), 3);
    l_if.i_req0 = 1'b1;
    l_if.i_data_in = 32'h1; cyc;
    l_if.i_data_in = 32'h2; cyc;
    l_if.i_req1 = 1'b1;
    l_if.i_data_in = 32'h9; cyc;
    l_if.i_req0 = 1'b0;
    chk("lifo_both_data", l_if.o_exp_data, 32'h2);
    chk("lifo_both_count", 32'(l_if.o_count), 2);
    l_if.i_data_obs = 32'h2; cyc;
    chk("lifo_replaced_top", l_if.o_exp_data, 32'h9);
    l_if.i_data_obs = 32'h9; cyc;
    chk("lifo_bottom", l_if.o_exp_data, 32'h1);
    l_if.i_data_obs = 32'h1;
    l_if.i_req1 = 1'b0; cyc;
    chk("lifo_empty2", 32'(l_if.o_empty), 1);

    // Pop while empty
    f_if.i_req1 = 1'b1; cyc;
    f_if.i_req1 = 1'b0;
    chk("unf_flag", 32'(f_if.o_underflow), 1);
    chk("unf_vld", 32'(f_if.o_exp_valid), 0);
    chk("unf_count", 32'(f_if.o_count), 0);

    // Wrong observed data
    f_if.i_req0 = 1'b1; f_if.i_data_in = 32'h5; cyc;
    f_if.i_req0 = 1'b0; f_if.i_req1 = 1'b1; cyc;
    f_if.i_req1 = 1'b0;
    chk("mm_exp", f_if.o_exp_data, 32'h5);
    f_if.i_data_obs = 32'h6; cyc;
    chk("mm_pulse", 32'(f_if.o_mismatch), 1);
    chk("mm_err1", 32'(f_if.o_err_cnt), 1);
    cyc;
    chk("mm_pulse_end", 32'(f_if.o_mismatch), 0);
    chk("mm_match_same", 32'(f_if.o_match_cnt), 3);

    // Fill, overflow, push+pop while full, then drain through the wrap
    f_if.i_req0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      f_if.i_data_in = 32'h100 + 32'(i);
      cyc;
    end
    f_if.i_req0 = 1'b0;
    chk("full_count", 32'(f_if.o_count), 16);
    chk("full_flag", 32'(f_if.o_full), 1);
    f_if.i_req0 = 1'b1; f_if.i_data_in = 32'hDEAD; cyc;
    chk("ovf_flag", 32'(f_if.o_overflow), 1);
    chk("ovf_count", 32'(f_if.o_count), 16);
    chk("ovf_vld", 32'(f_if.o_exp_valid), 0);
    f_if.i_req1 = 1'b1; f_if.i_data_in = 32'hBEEF; cyc;
    f_if.i_req0 = 1'b0;
    chk("fullboth_count", 32'(f_if.o_count), 16);
    chk("fullboth_vld", 32'(f_if.o_exp_valid), 1);
    chk("fullboth_oldest", f_if.o_exp_data, 32'h100);
    f_if.i_data_obs = 32'h100;
    for (int i = 1; i < 16; i++) begin
      cyc;
      chk("drain", f_if.o_exp_data, 32'h100 + 32'(i));
      f_if.i_data_obs = 32'h100 + 32'(i);
    end
    cyc;
    chk("drain_appended", f_if.o_exp_data, 32'hBEEF);
    f_if.i_data_obs = 32'hBEEF;
    f_if.i_req1 = 1'b0; cyc;
    chk("drain_empty", 32'(f_if.o_empty), 1);
    chk("drain_match", 32'(f_if.o_match_cnt), 20);
    chk("drain_err", 32'(f_if.o_err_cnt), 1);

    // Reset mid-operation with a compare pending
    f_if.i_req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f_if.i_data_in = 32'h50 + 32'(i);
      cyc;
    end
    f_if.i_req0 = 1'b0;
    chk("pre_rst_count", 32'(f_if.o_count), 5);
    f_if.i_req1 = 1'b1; cyc;
    f_if.i_req1 = 1'b0;
    f_if.i_data_obs = 32'hFFFF;
    chk("pre_rst_vld", 32'(f_if.o_exp_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(f_if.o_count), 0);
    chk("mid_rst_empty", 32'(f_if.o_empty), 1);
    chk("mid_rst_vld", 32'(f_if.o_exp_valid), 0);
    chk("mid_rst_data", f_if.o_exp_data, 0);
    chk("mid_rst_match", 32'(f_if.o_match_cnt), 0);
    chk("mid_rst_err", 32'(f_if.o_err_cnt), 0);
    chk("mid_rst_ovf", 32'(f_if.o_overflow), 0);
    chk("mid_rst_unf", 32'(f_if.o_underflow), 0);
    #2 rst = 1'b0;
    cyc;
    chk("post_rst_vld", 32'(f_if.o_exp_valid), 0);
    chk("post_rst_count", 32'(f_if.o_count), 0);
    chk("post_rst_err", 32'(f_if.o_err_cnt), 0);
    chk("post_rst_mismatch", 32'(f_if.o_mismatch), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
